// File: rtl/adc_pkg.sv
// Shared ADC definitions: channel map, data widths and the command responder's state encoding.
package adc_pkg;

   localparam int unsigned ADC_DATA_W   = 12;
   localparam int unsigned CH_W         = 5;
   localparam logic [4:0]  TEMP_CHANNEL = 5'd17;
   localparam logic [4:0]  MAX_CHANNEL  = 5'd17;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StConvert = 2'd1,
      StRespond = 2'd2
   } adc_state_e;

endpackage

// File: rtl/adc_cmd_responder.sv
// ADC command/response model: accepts one channel command, waits CONV_CYCLES clocks, then
// returns the captured sample (or a fixed code for the temperature diode) as a one-cycle strobe.
module adc_cmd_responder
   import adc_pkg::*;
#(
   parameter int unsigned           CONV_CYCLES = 20,
   parameter logic [ADC_DATA_W-1:0] TEMP_CODE   = 12'd3600
) (
   input  logic                  clock_in,
   input  logic                  reset_n,
   input  logic                  command_valid,
   input  logic [CH_W-1:0]       command_channel,
   input  logic                  command_startofpacket,
   input  logic                  command_endofpacket,
   output logic                  command_ready,
   input  logic [ADC_DATA_W-1:0] sample_in,
   output logic                  response_valid,
   output logic [CH_W-1:0]       response_channel,
   output logic [ADC_DATA_W-1:0] response_data,
   output logic                  response_startofpacket,
   output logic                  response_endofpacket,
   output logic                  cmd_error
);

   localparam logic [7:0] COUNT_INIT = 8'(CONV_CYCLES - 1);

   adc_state_e            state_q, state_d;
   logic [7:0]            count_q, count_d;
   logic [CH_W-1:0]       cap_ch_q;
   logic                  cap_sop_q, cap_eop_q;
   logic [ADC_DATA_W-1:0] cap_sample_q;
   logic [CH_W-1:0]       resp_ch_q;
   logic [ADC_DATA_W-1:0] resp_data_q;
   logic                  resp_sop_q, resp_eop_q;
   logic                  err_q;

   logic                  accept;
   logic                  illegal;
   logic                  enter_resp;

   assign illegal = (command_channel > MAX_CHANNEL);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      accept     = 1'b0;
      enter_resp = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (command_valid) begin
               accept = 1'b1;
               // Illegal channels are consumed here without a conversion.
               if (!illegal) begin
                  state_d = StConvert;
                  count_d = COUNT_INIT;
               end
            end
         end
         StConvert: begin
            if (count_q == 8'd0) begin
               state_d    = StRespond;
               enter_resp = 1'b1;
            end else begin
               count_d = count_q - 8'd1;
            end
         end
         StRespond: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         count_q      <= 8'd0;
         cap_ch_q     <= '0;
         cap_sop_q    <= 1'b0;
         cap_eop_q    <= 1'b0;
         cap_sample_q <= '0;
         resp_ch_q    <= '0;
         resp_data_q  <= '0;
         resp_sop_q   <= 1'b0;
         resp_eop_q   <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         err_q   <= accept && illegal;
         if (accept) begin
            cap_ch_q     <= command_channel;
            cap_sop_q    <= command_startofpacket;
            cap_eop_q    <= command_endofpacket;
            cap_sample_q <= sample_in;
         end
         // Response fields are only written on entry to RESPOND and hold until the next one.
         if (enter_resp) begin
            resp_ch_q   <= cap_ch_q;
            resp_data_q <= (cap_ch_q == TEMP_CHANNEL) ? TEMP_CODE : cap_sample_q;
            resp_sop_q  <= cap_sop_q;
            resp_eop_q  <= cap_eop_q;
         end
      end
   end

   assign command_ready          = (state_q == StIdle);
   assign response_valid         = (state_q == StRespond);
   assign response_channel       = resp_ch_q;
   assign response_data          = resp_data_q;
   assign response_startofpacket = resp_sop_q;
   assign response_endofpacket   = resp_eop_q;
   assign cmd_error              = err_q;

endmodule

// File: doc/adc_cmd_responder.md
ADC_CMD_RESPONDER -- requirements
Module: adc_cmd_responder

Interface
REQ-001 SHALL have parameter CONV_CYCLES, default 20, conversion time in clocks (legal 1..255).
REQ-002 SHALL have parameter TEMP_CODE, default 12'd3600, 12-bit code returned for the temperature-diode channel.
REQ-003 clock_in  input  1  sole clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 command_valid  input  1  command request.
REQ-006 command_channel  input  5  requested channel.
REQ-007 command_startofpacket  input  1  command SOP tag.
REQ-008 command_endofpacket  input  1  command EOP tag.
REQ-009 command_ready  output  1  responder can accept a command.
REQ-010 sample_in  input  12  stand-in analog value for channels 0..16.
REQ-011 response_valid  output  1  one-cycle response strobe; no backpressure.
REQ-012 response_channel  output  5  channel of the current response.
REQ-013 response_data  output  12  conversion result.
REQ-014 response_startofpacket / response_endofpacket  output  1 each  echoed command tags.
REQ-015 cmd_error  output  1  one-cycle pulse on an illegal-channel command.

Function
REQ-016 FSM states SHALL be IDLE, CONVERT, RESPOND.
REQ-017 command_ready SHALL be 1 only in IDLE; a command is accepted on an edge where command_valid and command_ready are both 1.
REQ-018 On acceptance, the block SHALL capture channel, SOP, EOP, and sample_in. It SHALL load an 8-bit countdown with CONV_CYCLES-1 and enter CONVERT.
REQ-019 CONVERT SHALL decrement each cycle and enter RESPOND on the edge where the count is 0, so CONVERT lasts exactly CONV_CYCLES cycles.
REQ-020 RESPOND SHALL last one cycle with response_valid=1, then return to IDLE.
REQ-021 Latency: response_valid SHALL be high in the cycle beginning CONV_CYCLES+1 edges after the accepting edge; sustained throughput SHALL be one command per CONV_CYCLES+2 cycles.
REQ-022 Response data SHALL be TEMP_CODE for channel 17 and the captured sample_in for channels 0..16.
REQ-023 sample_in changes after acceptance SHALL NOT affect the pending response.
REQ-024 response_channel, response_data and the SOP/EOP tags SHALL update on the edge entering RESPOND. They SHALL hold their values until the next response.
REQ-025 For channels 18..31, the command SHALL be accepted and cmd_error SHALL pulse for the cycle after acceptance. There SHALL be no conversion and no response; the FSM SHALL return to IDLE, with ready high again in that same cycle.
REQ-026 command_valid held high continuously SHALL cause back-to-back conversions with no lost or duplicated responses.
REQ-027 Command inputs while command_ready=0 SHALL be ignored.

Reset
REQ-028 Asserting reset_n=0 SHALL immediately force IDLE, command_ready=1, response_valid=0, cmd_error=0, count=0, response_channel=0, response_data=0, SOP=0, EOP=0.
REQ-029 Reset during CONVERT or RESPOND SHALL discard the pending conversion; no response SHALL follow deassertion.
REQ-030 After deassertion, the first accepting edge SHALL be the first rising edge with command_valid=1.

Structure
REQ-031 Shared package adc_pkg SHALL hold TEMP_CHANNEL=5'd17, MAX_CHANNEL=5'd17, ADC_DATA_W=12, CH_W=5 and the FSM state encoding, for reuse by ADC consumers.
REQ-032 No sub-module; the FSM, countdown and capture registers SHALL be one module.

Verification (CONV_CYCLES=4, TEMP_CODE=3600)
REQ-033 Temperature command: valid=1, ch=17 for one cycle -> response_valid exactly 5 edges later, one cycle, data=3600, ch=17.
REQ-034 sample_in=0x2A5 at acceptance of ch=3, then changed to 0xFFF -> response data=0x2A5, ch=3.
REQ-035 command_valid tied 1, ch=17, 3 responses -> response_valid period 6 cycles, ready high one cycle per period.
REQ-036 Illegal ch=20 -> cmd_error high one cycle after acceptance, no response_valid, next command accepted immediately.
REQ-037 reset_n low for one cycle during CONVERT, then released -> no response_valid, all outputs at reset values, next ch=17 command completes normally.
REQ-038 Two responses (ch=17, then ch=5 with sample_in=100) -> response_data holds 3600 between strobes, then 100.
